load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
CPU-side initiator for the byte-serial memory controller's start/done handshake. Accepts one decoded load/store from execute, computes the effective address, and issues exactly one start pulse with stable operands. It waits for done, then returns load data to register writeback. Also detects illegal or misaligned requests and controllers that never respond.

Parameters:
TIMEOUT, 15, maximum cycles spent in WAIT without mem_done before a timeout fault.
CHECK_ALIGN, 0, 1 = reject halfword addresses with addr[0]!=0 and word addresses with addr[1:0]!=0.

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  execute stage presents a load/store
req_ready  out  1  high when state==IDLE and mem_active==0; a request is accepted on req_valid&&req_ready
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  load/store FUNC3
req_base  in  32  rs1 value
req_imm  in  32  sign-extended offset
req_store_data  in  32  rs2 value
req_rd  in  5  load destination register
mem_start  out  1  one-cycle start pulse to the memory controller
mem_address  out  32  effective address; held from ISSUE until return to IDLE
mem_mode  out  3  funct3; held with mem_address
mem_write_enable  out  1  high only during ISSUE/WAIT of a store
mem_write_data  out  32  store data; held with mem_address
mem_done  in  1  controller completion pulse; mem_read_data valid in the same cycle
mem_read_data  in  32  extended load result from the controller
mem_active  in  1  controller busy
op_done  out  1  one-cycle pulse per successfully completed operation
wb_valid  out  1  one-cycle pulse; load completed and rd!=0
wb_rd  out  5  destination register
wb_data  out  32  load result
fault_valid  out  1  one-cycle fault pulse
fault_code  out  2  01 illegal funct3, 10 misaligned, 11 timeout
fault_addr  out  32  effective address of the faulting request

Behaviour:
- Reset values: state IDLE; mem_start, mem_write_enable, op_done, wb_valid and fault_valid 0; all other registered outputs 0.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, on accept:
  - Register address = req_base + req_imm (mod 2^32), funct3, store flag, data and rd.
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Illegal request: stay in IDLE; next cycle fault_valid=1, code 01, no mem_start.
  - Misaligned request with CHECK_ALIGN=1: stay in IDLE; next cycle code 10, no mem_start.
  - Otherwise go to ISSUE.
- ISSUE, exactly one cycle: mem_start=1; mem_write_enable=store flag. Go to WAIT; clear the timeout counter.
- WAIT:
  - mem_start=0; operands and mem_write_enable stay constant.
  - Counter increments each cycle.
  - On mem_done: capture mem_read_data. Next cycle op_done=1; for a load, wb_valid=(rd!=0), wb_rd, wb_data. Return to IDLE.
  - If counter==TIMEOUT and no mem_done: fault code 11, return to IDLE. If mem_done arrives in the same cycle, mem_done wins.
- mem_write_enable drops to 0 on the edge that leaves WAIT. It is never high in IDLE, because memory writes whenever write_enable is high.
- mem_done in IDLE or ISSUE (stale, e.g. after reset) is ignored.
- Extension is performed by the controller; mem_read_data is forwarded unmodified.
- Latency, with the accept edge at the end of cycle A: mem_start in cycle A+1. wb_valid/op_done in A+4 for byte, A+5 for halfword, A+7 for word.
- Reset mid-operation: IDLE and write_enable 0 after the reset edge, no pulses. req_ready stays low until mem_active falls.
- req_ready is low in ISSUE and WAIT, so back-to-back requests cannot overlap. The earliest next accept is the cycle op_done is high.

Decomposition:
- Add funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW), FSM state encodings and fault codes to the shared arch_defines.v include.
- Legality/alignment check is a local function.
- No sub-module; the timeout counter is width $clog2(TIMEOUT+1) inline.

Test Plan:
- LB at 0x100 holding 0x80 (base 0xFC, imm 4) -> mem_address 0x100; wb_data 0xFFFFFF80 in A+4; LBU -> 0x00000080.
- SW 0xDEADBEEF at 0x200, then LW rd=5 from 0x200 -> wb_rd 5, wb_data 0xDEADBEEF in A+7; mem_write_enable high only during the store.
- LH 0x8001, then LHU from the same address -> 0xFFFF8001 / 0x00008001 in A+5; LW with rd=0 -> op_done=1, wb_valid=0.
- Load funct3=011 -> fault_code 01 next cycle, mem_start never asserted. With CHECK_ALIGN=1, LW at 0x102 -> fault_code 10.
- Stubbed controller with done tied low -> fault_code 11 after TIMEOUT WAIT cycles, then req_ready returns high. Done on exactly the TIMEOUT cycle -> op_done, no fault.
- Reset during a word store's WAIT -> mem_write_enable 0 the next cycle; the stale mem_done is ignored; req_ready waits for mem_active==0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM states and fault codes shared by the load/store unit
package load_store_unit_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_ILLEGAL  = 2'b01,
    FLT_MISALIGN = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } fault_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: start/done bus between the load/store unit and the memory controller
interface load_store_unit_if;
  logic        start;
  logic [31:0] address;
  logic [2:0]  mode;
  logic        write_enable;
  logic [31:0] write_data;
  logic        done;
  logic [31:0] read_data;
  logic        active;
  modport master (
    output start, address, mode, write_enable, write_data,
    input  done, read_data, active
  );
  modport slave (
    input  start, address, mode, write_enable, write_data,
    output done, read_data, active
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: issues one memory start per accepted load/store, returns load data, reports faults
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT     = 15,
  parameter bit CHECK_ALIGN = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_base,
  input  logic [31:0]              req_imm,
  input  logic [31:0]              req_store_data,
  input  logic [4:0]               req_rd,
  load_store_unit_if.master        mem,
  output logic                     op_done,
  output logic                     wb_valid,
  output logic [4:0]               wb_rd,
  output logic [31:0]              wb_data,
  output logic                     fault_valid,
  output logic [1:0]               fault_code,
  output logic [31:0]              fault_addr
);
  localparam int CW = $clog2(TIMEOUT + 1);

  function automatic fault_t check(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    logic mis;
    legal = st ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
               : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    mis = CHECK_ALIGN && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00));
    return !legal ? FLT_ILLEGAL : mis ? FLT_MISALIGN : FLT_NONE;
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q;
  logic [2:0]    f3_q;
  logic          store_q;
  logic [4:0]    rd_q;
  logic [31:0]   eff;
  logic          accept, timeout, done_w;
  fault_t        chk;

  assign eff     = req_base + req_imm;
  assign accept  = req_valid && req_ready;
  assign chk     = check(req_store, req_funct3, eff);
  assign done_w  = state == S_WAIT && mem.done;
  assign timeout = state == S_WAIT && !mem.done && cnt == CW'(TIMEOUT);
  assign fault_addr = addr_q;

  // State register
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : state_n;

  // Next state and bus outputs; write enable is derived from state so it can never be high in IDLE
  always_comb begin
    req_ready        = state == S_IDLE && !mem.active;
    mem.start        = state == S_ISSUE;
    mem.write_enable = store_q && state != S_IDLE;
    mem.address      = addr_q;
    mem.mode         = f3_q;
    mem.write_data   = wdata_q;
    state_n = state == S_IDLE  ? ((accept && chk == FLT_NONE) ? S_ISSUE : S_IDLE) :
              state == S_ISSUE ? S_WAIT :
              (mem.done || timeout) ? S_IDLE : S_WAIT;
  end

  // Operand capture, timeout counter and one-cycle completion/fault pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      store_q     <= 1'b0;
      rd_q        <= '0;
      cnt         <= '0;
      op_done     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      fault_valid <= 1'b0;
      fault_code  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= eff;
        wdata_q <= req_store_data;
        f3_q    <= req_funct3;
        store_q <= req_store;
        rd_q    <= req_rd;
      end
      cnt         <= state == S_WAIT ? cnt + CW'(1) : '0;
      op_done     <= done_w;
      wb_valid    <= done_w && !store_q && rd_q != 5'd0;
      fault_valid <= (accept && chk != FLT_NONE) || timeout;
      if (done_w && !store_q) begin
        wb_rd   <= rd_q;
        wb_data <= mem.read_data;
      end
      if (accept && chk != FLT_NONE)
        fault_code <= chk;
      else if (timeout)
        fault_code <= FLT_TIMEOUT;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a behavioural byte-serial memory controller
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_base = '0, req_imm = '0, req_store_data = '0;
  logic [4:0]  req_rd = '0;
  logic        op_done, wb_valid, fault_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;
  logic [1:0]  fault_code;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(15), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .mem(bus),
    .op_done(op_done), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault_valid(fault_valid), .fault_code(fault_code), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        flt;
    logic [1:0]  code;
    logic [31:0] addr;
    logic        wbv;
    logic [4:0]  rd;
    logic [31:0] data;
    int          at;
  } rsp_t;
  typedef struct {
    logic [31:0] addr;
    logic [2:0]  mode;
    logic        we;
    logic [31:0] wdata;
  } iss_t;

  rsp_t rq[$];
  iss_t iq[$];
  rsp_t re;
  iss_t ie;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Memory controller model: done arrives 2/3/5 cycles after start for byte/half/word
  logic [7:0] mb [0:1023];
  logic       dead = 1'b0;
  int         ovr = 0;
  logic       busy = 1'b0;
  int         dcnt = 0;
  iss_t       cur;

  function automatic logic [31:0] rdmem(input logic [2:0] m, input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    case (m)
      3'b000:  return {{24{mb[i][7]}}, mb[i]};
      3'b100:  return {24'h0, mb[i]};
      3'b001:  return {{16{mb[i+1][7]}}, mb[i+1], mb[i]};
      3'b101:  return {16'h0, mb[i+1], mb[i]};
      default: return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
    endcase
  endfunction

  function automatic void wrmem(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    logic [9:0] i;
    i = a[9:0];
    mb[i] = d[7:0];
    if (m[1:0] != 2'b00) mb[i+1] = d[15:8];
    if (m[1:0] == 2'b10) begin
      mb[i+2] = d[23:16];
      mb[i+3] = d[31:24];
    end
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      bus.done = 1'b0;
      busy = 1'b0;
    end else if (busy) begin
      dcnt--;
      if (dcnt == 0) begin
        bus.read_data = rdmem(cur.mode, cur.addr);
        if (cur.we) wrmem(cur.mode, cur.addr, cur.wdata);
        bus.done = 1'b1;
      end
    end
    if (bus.start === 1'b1 && !busy && !dead) begin
      busy = 1'b1;
      cur.addr = bus.address;
      cur.mode = bus.mode;
      cur.we = bus.write_enable;
      cur.wdata = bus.write_data;
      dcnt = ovr != 0 ? ovr : bus.mode[1:0] == 2'b00 ? 2 : bus.mode[1:0] == 2'b01 ? 3 : 5;
    end
    bus.active = busy;
  end

  // Monitor: checks every start against the issue queue and every pulse against the response queue
  always @(negedge clk) begin
    if (bus.start === 1'b1) begin
      if (iq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_start: got start at %h expected none (cycle %0d)", bus.address, cyc);
      end else begin
        ie = iq.pop_front();
        chk("issue_addr", bus.address, ie.addr);
        chk("issue_mode", {29'h0, bus.mode}, {29'h0, ie.mode});
        chk("issue_we", {31'h0, bus.write_enable}, {31'h0, ie.we});
        if (ie.we) chk("issue_wdata", bus.write_data, ie.wdata);
      end
    end
    if (bus.write_enable === 1'b1)
      chk("we_outside_op", {31'h0, req_ready}, 32'h0);
    if (op_done === 1'b1 || fault_valid === 1'b1) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got op_done=%b fault_valid=%b expected none (cycle %0d)",
                 op_done, fault_valid, cyc);
      end else begin
        re = rq.pop_front();
        chk("rsp_cycle", cyc, re.at);
        chk("fault_valid", {31'h0, fault_valid}, {31'h0, re.flt});
        chk("op_done", {31'h0, op_done}, {31'h0, !re.flt});
        if (re.flt) begin
          chk("fault_code", {30'h0, fault_code}, {30'h0, re.code});
          chk("fault_addr", fault_addr, re.addr);
        end else begin
          chk("wb_valid", {31'h0, wb_valid}, {31'h0, re.wbv});
          chk("we_after_op", {31'h0, bus.write_enable}, 32'h0);
          if (re.wbv) begin
            chk("wb_rd", {27'h0, wb_rd}, {27'h0, re.rd});
            chk("wb_data", wb_data, re.data);
          end
        end
      end
    end
  end

  // One request: ea/code/lat/rdata are hand-computed; lat < 0 means no response is expected
  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                     input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] ea,
                     input logic [1:0] code, input int lat, input logic [31:0] rdata);
    int   t;
    iss_t i;
    rsp_t r;
    t = 0;
    @(negedge clk); #1;
    while (!req_ready && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_wait: got req_ready=0 expected 1 within 200 cycles");
      return;
    end
    if (code == 2'b00 || code == 2'b11) begin
      i.addr = ea; i.mode = f3; i.we = st; i.wdata = sd;
      iq.push_back(i);
    end
    if (lat >= 0) begin
      r.flt = code != 2'b00; r.code = code; r.addr = ea;
      r.wbv = !st && rd != 5'd0; r.rd = rd; r.data = rdata; r.at = cyc + lat;
      rq.push_back(r);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_base = base; req_imm = imm; req_store_data = sd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || iq.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (rq.size() != 0 || iq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d responses and %0d issues pending expected 0", rq.size(), iq.size());
      rq.delete();
      iq.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    bus.done = 1'b0;
    bus.active = 1'b0;
    bus.read_data = '0;
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    mb[10'h100] = 8'h80;
    mb[10'h180] = 8'h01;
    mb[10'h181] = 8'h80;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_start", {31'h0, bus.start}, 32'h0);
    chk("rst_we", {31'h0, bus.write_enable}, 32'h0);
    chk("rst_addr", bus.address, 32'h0);
    chk("rst_op_done", {31'h0, op_done}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_fault_valid", {31'h0, fault_valid}, 32'h0);
    chk("rst_fault_code", {30'h0, fault_code}, 32'h0);
    // Loads and stores through the controller
    req(1'b0, F3_LB,  32'h0FC, 32'h4,        32'h0,        5'd1, 32'h100, 2'b00, 4, 32'hFFFFFF80);
    req(1'b0, F3_LBU, 32'h100, 32'h0,        32'h0,        5'd2, 32'h100, 2'b00, 4, 32'h00000080);
    req(1'b1, F3_SW,  32'h1F0, 32'h10,       32'hDEADBEEF, 5'd9, 32'h200, 2'b00, 7, 32'h0);
    req(1'b0, F3_LW,  32'h204, 32'hFFFFFFFC, 32'h0,        5'd5, 32'h200, 2'b00, 7, 32'hDEADBEEF);
    req(1'b0, F3_LH,  32'h180, 32'h0,        32'h0,        5'd6, 32'h180, 2'b00, 5, 32'hFFFF8001);
    req(1'b0, F3_LHU, 32'h17F, 32'h1,        32'h0,        5'd7, 32'h180, 2'b00, 5, 32'h00008001);
    req(1'b0, F3_LW,  32'h200, 32'h0,        32'h0,        5'd0, 32'h200, 2'b00, 7, 32'h0);
    req(1'b1, F3_SB,  32'h101, 32'h0,        32'h0000005A, 5'd0, 32'h101, 2'b00, 4, 32'h0);
    req(1'b0, F3_LBU, 32'h101, 32'h0,        32'h0,        5'd4, 32'h101, 2'b00, 4, 32'h0000005A);
    // Illegal and misaligned requests fault the next cycle with no start
    req(1'b0, 3'b011, 32'h200, 32'h0,        32'h0,        5'd3, 32'h200, 2'b01, 1, 32'h0);
    req(1'b1, 3'b100, 32'h204, 32'h0,        32'h1,        5'd3, 32'h204, 2'b01, 1, 32'h0);
    req(1'b0, F3_LW,  32'h100, 32'h2,        32'h0,        5'd3, 32'h102, 2'b10, 1, 32'h0);
    req(1'b1, F3_SH,  32'h181, 32'h0,        32'h1234,     5'd3, 32'h181, 2'b10, 1, 32'h0);
    drain();
    // Controller that never answers: timeout fault after WAIT counts 0..15
    dead = 1'b1;
    req(1'b0, F3_LW,  32'h200, 32'h0,        32'h0,        5'd8, 32'h200, 2'b11, 18, 32'h0);
    drain();
    @(negedge clk); #1;
    chk("ready_after_timeout", {31'h0, req_ready}, 32'h1);
    dead = 1'b0;
    // Done on the very cycle the counter reaches TIMEOUT: completion wins
    ovr = 16;
    req(1'b0, F3_LW,  32'h200, 32'h0,        32'h0,        5'd8, 32'h200, 2'b00, 18, 32'hDEADBEEF);
    drain();
    ovr = 0;
    // Reset during a word store's WAIT
    req(1'b1, F3_SW,  32'h300, 32'h0,        32'h11223344, 5'd0, 32'h300, 2'b00, -1, 32'h0);
    t = 0;
    while (bus.start !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_test_start_seen", {31'h0, bus.start}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", {31'h0, bus.write_enable}, 32'h0);
    chk("mid_rst_start", {31'h0, bus.start}, 32'h0);
    chk("mid_rst_ready_held", {31'h0, req_ready}, 32'h0);
    t = 0;
    while (bus.active && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    chk("mid_rst_active_falls", {31'h0, bus.active}, 32'h0);
    chk("mid_rst_ready_back", {31'h0, req_ready}, 32'h1);
    req(1'b0, F3_LB,  32'h100, 32'h0,        32'h0,        5'd3, 32'h100, 2'b00, 4, 32'hFFFFFF80);
    drain();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
